ysyx_040066_clint_mh: RTL and testbench

Multi-hart core-local interruptor (CLINT) on the ysyx_040066 data-memory path, sitting between the LSU and the data bus. It decodes the CLINT window, diverts hits away from memory, and implements a prescaled shared `mtime`, one `mtimecmp` and one `msip` per hart, and byte-masked writes. Reads are registered, and the timer and software interrupt lines are registered per hart.

---
 rtl/ysyx_040066_clint_mh_if.sv | 24 ++
 rtl/ysyx_040066_clint_mh.sv | 128 ++++++++++++
 tb/tb_ysyx_040066_clint_mh.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_040066_clint_mh_if.sv
// LSU-side data-memory bus seen by the CLINT.
// The CLINT diverts window hits away from memory and returns registered reads.
interface ysyx_040066_clint_mh_if;
    logic [63:0] addr;
    logic        MemRd;
    logic        MemWr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic        MemRd_real;
    logic        MemWr_real;
    logic        rd_hit;
    logic [63:0] rdata;
    logic        error;

    modport master (
        output addr, MemRd, MemWr, wdata, wmask,
        input  MemRd_real, MemWr_real, rd_hit, rdata, error
    );

    modport slave (
        input  addr, MemRd, MemWr, wdata, wmask,
        output MemRd_real, MemWr_real, rd_hit, rdata, error
    );
endinterface

// File: rtl/ysyx_040066_clint_mh.sv
// Multi-hart CLINT: prescaled shared mtime, per-hart mtimecmp/msip,
// byte-masked writes, registered reads and interrupt lines.
module ysyx_040066_clint_mh #(
    parameter int          NHART    = 1,
    parameter int          TICK_DIV = 1,
    parameter logic [63:0] BASE     = 64'h2000000,
    parameter logic [63:0] CMP_RST  = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic                    clk,
    input  logic                    rst,
    ysyx_040066_clint_mh_if.slave   bus,
    output logic [NHART-1:0]        mtip,
    output logic [NHART-1:0]        msip_o
);

    logic [63:0]      mtime;
    logic [15:0]      pcnt;
    logic [63:0]      cmp [NHART];
    logic [NHART-1:0] msip;
    logic [NHART-1:0] tip;
    logic [63:0]      rdata_q;
    logic             rd_hit_q;
    logic             error_q;

    logic             hit;
    logic [63:0]      off64;
    logic [15:0]      off;
    logic             sel_mtime;
    logic [NHART-1:0] sel_cmp;
    logic [NHART-1:0] sel_msip;
    logic             mapped;
    logic             msip_bit;
    logic             msip_en;
    logic [63:0]      rd_val;
    logic             wr_hit;
    logic             rd_hit_now;
    logic             tick;
    logic             unused_off;

    function automatic logic [63:0] merge(
        input logic [63:0] old,
        input logic [63:0] wd,
        input logic [7:0]  m
    );
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    assign hit        = (bus.addr >= BASE) && (bus.addr < BASE + 64'hC000);
    assign off64      = bus.addr - BASE;
    assign off        = off64[15:0];
    assign unused_off = ^{off64[63:16], off[1:0]};

    assign bus.MemRd_real = bus.MemRd & ~hit;
    assign bus.MemWr_real = bus.MemWr & ~hit;
    assign bus.rd_hit     = rd_hit_q;
    assign bus.rdata      = rdata_q;
    assign bus.error      = error_q;
    assign mtip           = tip;
    assign msip_o         = msip;

    assign wr_hit     = bus.MemWr & hit;
    assign rd_hit_now = bus.MemRd & hit;
    assign tick       = (pcnt == 16'(TICK_DIV - 1));

    // msip is a 32-bit register; addr[2] picks which half of the doubleword
    assign msip_bit = off[2] ? bus.wdata[32] : bus.wdata[0];
    assign msip_en  = off[2] ? bus.wmask[4]  : bus.wmask[0];

    always_comb begin
        sel_mtime = hit && (off[15:3] == 13'h17FF);
        sel_cmp   = '0;
        sel_msip  = '0;
        rd_val    = '0;
        for (int h = 0; h < NHART; h++) begin
            sel_cmp[h]  = hit && (off[15:3] == 13'(13'h800 + h));
            sel_msip[h] = hit && (off[15:2] == 14'(h));
        end
        mapped = sel_mtime | (|sel_cmp) | (|sel_msip);
        if (sel_mtime) rd_val = mtime;
        for (int h = 0; h < NHART; h++) begin
            if (sel_cmp[h]) rd_val = cmp[h];
            if (sel_msip[h]) begin
                rd_val = off[2] ? {31'b0, msip[h], 32'b0}
                                : {63'b0, msip[h]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime    <= '0;
            pcnt     <= '0;
            msip     <= '0;
            tip      <= '0;
            rdata_q  <= '0;
            rd_hit_q <= 1'b0;
            error_q  <= 1'b0;
            for (int h = 0; h < NHART; h++) cmp[h] <= CMP_RST;
        end else begin
            // a store to mtime wins over the tick and restarts the prescaler
            if (wr_hit && sel_mtime) begin
                mtime <= merge(mtime, bus.wdata, bus.wmask);
                pcnt  <= '0;
            end else if (tick) begin
                mtime <= mtime + 64'd1;
                pcnt  <= '0;
            end else begin
                pcnt  <= pcnt + 16'd1;
            end
            for (int h = 0; h < NHART; h++) begin
                if (wr_hit && sel_cmp[h])
                    cmp[h] <= merge(cmp[h], bus.wdata, bus.wmask);
                if (wr_hit && sel_msip[h] && msip_en)
                    msip[h] <= msip_bit;
                tip[h] <= (mtime >= cmp[h]);
            end
            rd_hit_q <= rd_hit_now;
            rdata_q  <= rd_hit_now ? rd_val : 64'd0;
            error_q  <= (bus.MemRd | bus.MemWr) & hit & ~mapped;
        end
    end

endmodule

// File: tb/tb_ysyx_040066_clint_mh.sv
// Directed bench: dut_a (2 harts, TICK_DIV=1), dut_b (1 hart, TICK_DIV=4).
module tb_ysyx_040066_clint_mh;
    localparam logic [63:0] BASE = 64'h2000000;
    localparam logic [63:0] A_MTIME = BASE + 64'hBFF8;
    localparam logic [63:0] A_CMP0  = BASE + 64'h4000;
    localparam logic [63:0] A_CMP1  = BASE + 64'h4008;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_n = 0;
    int   chk_n  = 0;

    logic [1:0] mtip_a, msip_a;
    logic [0:0] mtip_b, msip_b;

    ysyx_040066_clint_mh_if bus_a();
    ysyx_040066_clint_mh_if bus_b();

    ysyx_040066_clint_mh #(.NHART(2), .TICK_DIV(1), .BASE(BASE)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .mtip(mtip_a), .msip_o(msip_a)
    );

    ysyx_040066_clint_mh #(.NHART(1), .TICK_DIV(4), .BASE(BASE)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .mtip(mtip_b), .msip_o(msip_b)
    );

    always #5 clk = ~clk;

    task automatic drv_a(input logic rd, input logic wr, input logic [63:0] a,
                         input logic [63:0] wd, input logic [7:0] m);
        bus_a.MemRd = rd; bus_a.MemWr = wr; bus_a.addr = a;
        bus_a.wdata = wd; bus_a.wmask = m;
    endtask

    task automatic drv_b(input logic rd, input logic wr, input logic [63:0] a,
                         input logic [63:0] wd, input logic [7:0] m);
        bus_b.MemRd = rd; bus_b.MemWr = wr; bus_b.addr = a;
        bus_b.wdata = wd; bus_b.wmask = m;
    endtask

    task automatic test_reset;
        drv_a(0, 0, 64'd0, 64'd0, 8'd0);
        drv_b(0, 0, 64'd0, 64'd0, 8'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_n++;
        if ({bus_a.rdata, bus_a.rd_hit, bus_a.error} !== 66'd0)
            $display("FAIL reset_a_bus got %h/%b/%b want 0", bus_a.rdata, bus_a.rd_hit, bus_a.error);
        else pass_n++;
        chk_n++;
        if ({mtip_a, msip_a, mtip_b, msip_b} !== 6'd0)
            $display("FAIL reset_irq got %b want 0", {mtip_a, msip_a, mtip_b, msip_b});
        else pass_n++;
        rst = 1'b0;
    endtask

    task automatic test_idle_mtime;
        repeat (10) @(negedge clk);
        drv_a(1, 0, A_MTIME, 64'd0, 8'd0);
        #1;
        chk_n++;
        if (bus_a.MemRd_real !== 1'b0)
            $display("FAIL mtime_rd_real got %b want 0", bus_a.MemRd_real);
        else pass_n++;
        @(negedge clk);
        chk_n++;
        if (bus_a.rdata !== 64'h0A || bus_a.rd_hit !== 1'b1)
            $display("FAIL mtime_10 got %h/%b want 0a/1", bus_a.rdata, bus_a.rd_hit);
        else pass_n++;
        chk_n++;
        if (mtip_a !== 2'b00) $display("FAIL mtip_idle got %b want 00", mtip_a);
        else pass_n++;
        drv_a(0, 0, 64'd0, 64'd0, 8'd0);
        @(negedge clk);
        chk_n++;
        if (bus_a.rdata !== 64'd0 || bus_a.rd_hit !== 1'b0)
            $display("FAIL rdata_hold got %h/%b want 0/0", bus_a.rdata, bus_a.rd_hit);
        else pass_n++;
    endtask

    task automatic test_mtimecmp_tip;
        drv_a(0, 1, A_CMP1, 64'h20, 8'hFF);
        @(negedge clk);
        drv_a(0, 1, A_MTIME, 64'd0, 8'hFF);
        @(negedge clk);
        drv_a(0, 0, 64'd0, 64'd0, 8'd0);
        for (int j = 1; j <= 33; j++) begin
            @(negedge clk);
            if (j == 32) begin
                chk_n++;
                if (mtip_a !== 2'b00) $display("FAIL mtip_before got %b want 00", mtip_a);
                else pass_n++;
            end
            if (j == 33) begin
                chk_n++;
                if (mtip_a !== 2'b10) $display("FAIL mtip_after got %b want 10", mtip_a);
                else pass_n++;
            end
        end
    endtask

    task automatic test_byte_mask;
        drv_a(0, 1, A_CMP0, 64'h1122334455667788, 8'h0F);
        @(negedge clk);
        drv_a(1, 0, A_CMP0, 64'd0, 8'd0);
        @(negedge clk);
        chk_n++;
        if (bus_a.rdata !== 64'hFFFFFFFF55667788)
            $display("FAIL byte_mask got %h want ffffffff55667788", bus_a.rdata);
        else pass_n++;
        drv_a(1, 1, A_CMP0, 64'h0123456789ABCDEF, 8'hF0);
        @(negedge clk);
        chk_n++;
        if (bus_a.rdata !== 64'hFFFFFFFF55667788 || bus_a.error !== 1'b0)
            $display("FAIL rdwr_old got %h/%b want ffffffff55667788/0", bus_a.rdata, bus_a.error);
        else pass_n++;
        drv_a(1, 0, A_CMP0, 64'd0, 8'd0);
        @(negedge clk);
        chk_n++;
        if (bus_a.rdata !== 64'h0123456755667788)
            $display("FAIL rdwr_new got %h want 0123456755667788", bus_a.rdata);
        else pass_n++;
    endtask

    task automatic test_msip;
        drv_a(0, 1, BASE + 64'd4, 64'h1_0000_0000, 8'h10);
        #1;
        chk_n++;
        if (bus_a.MemWr_real !== 1'b0)
            $display("FAIL msip_wr_real got %b want 0", bus_a.MemWr_real);
        else pass_n++;
        @(negedge clk);
        chk_n++;
        if (msip_a !== 2'b10) $display("FAIL msip_o got %b want 10", msip_a);
        else pass_n++;
        drv_a(1, 0, BASE + 64'd4, 64'd0, 8'd0);
        @(negedge clk);
        chk_n++;
        if (bus_a.rdata !== 64'h1_0000_0000)
            $display("FAIL msip_rd1 got %h want 100000000", bus_a.rdata);
        else pass_n++;
        drv_a(1, 0, BASE, 64'd0, 8'd0);
        @(negedge clk);
        chk_n++;
        if (bus_a.rdata !== 64'd0 || bus_a.error !== 1'b0)
            $display("FAIL msip_rd0 got %h/%b want 0/0", bus_a.rdata, bus_a.error);
        else pass_n++;
    endtask

    task automatic test_unmapped;
        drv_a(1, 0, BASE + 64'h8000, 64'd0, 8'd0);
        #1;
        chk_n++;
        if (bus_a.MemRd_real !== 1'b0)
            $display("FAIL hole_rd_real got %b want 0", bus_a.MemRd_real);
        else pass_n++;
        @(negedge clk);
        chk_n++;
        if (bus_a.rdata !== 64'd0 || bus_a.error !== 1'b1 || bus_a.rd_hit !== 1'b1)
            $display("FAIL hole_err got %h/%b/%b want 0/1/1", bus_a.rdata, bus_a.error, bus_a.rd_hit);
        else pass_n++;
        drv_a(1, 0, BASE + 64'hC000, 64'd0, 8'd0);
        #1;
        chk_n++;
        if (bus_a.MemRd_real !== 1'b1)
            $display("FAIL end_rd_real got %b want 1", bus_a.MemRd_real);
        else pass_n++;
        @(negedge clk);
        chk_n++;
        if (bus_a.rd_hit !== 1'b0 || bus_a.error !== 1'b0)
            $display("FAIL end_hit got %b/%b want 0/0", bus_a.rd_hit, bus_a.error);
        else pass_n++;
        drv_a(0, 1, BASE - 64'd8, 64'd0, 8'hFF);
        #1;
        chk_n++;
        if (bus_a.MemWr_real !== 1'b1)
            $display("FAIL below_wr_real got %b want 1", bus_a.MemWr_real);
        else pass_n++;
        drv_a(0, 0, 64'd0, 64'd0, 8'd0);
        drv_b(0, 1, BASE + 64'd4, 64'h1_0000_0000, 8'h10);
        @(negedge clk);
        chk_n++;
        if (bus_b.error !== 1'b1 || msip_b !== 1'b0)
            $display("FAIL b_msip1_err got %b/%b want 1/0", bus_b.error, msip_b);
        else pass_n++;
        drv_b(0, 0, 64'd0, 64'd0, 8'd0);
    endtask

    task automatic test_prescale;
        drv_b(0, 1, A_MTIME, 64'h100, 8'hFF);
        @(negedge clk);
        drv_b(0, 0, 64'd0, 64'd0, 8'd0);
        repeat (8) @(negedge clk);
        drv_b(1, 0, A_MTIME, 64'd0, 8'd0);
        @(negedge clk);
        chk_n++;
        if (bus_b.rdata !== 64'h102)
            $display("FAIL prescale_8 got %h want 102", bus_b.rdata);
        else pass_n++;
        drv_b(0, 1, A_MTIME, 64'h100, 8'hFF);
        @(negedge clk);
        drv_b(0, 0, 64'd0, 64'd0, 8'd0);
        @(negedge clk);
        drv_b(0, 1, A_MTIME, 64'h200, 8'h03);
        @(negedge clk);
        drv_b(0, 0, 64'd0, 64'd0, 8'd0);
        repeat (3) @(negedge clk);
        drv_b(1, 0, A_MTIME, 64'd0, 8'd0);
        @(negedge clk);
        chk_n++;
        if (bus_b.rdata !== 64'h200)
            $display("FAIL restart_pre got %h want 200", bus_b.rdata);
        else pass_n++;
        @(negedge clk);
        chk_n++;
        if (bus_b.rdata !== 64'h201)
            $display("FAIL restart_tick got %h want 201", bus_b.rdata);
        else pass_n++;
        drv_b(0, 0, 64'd0, 64'd0, 8'd0);
    endtask

    task automatic test_back_to_back;
        drv_a(1, 0, A_CMP1, 64'd0, 8'd0);
        @(negedge clk);
        chk_n++;
        if (bus_a.rdata !== 64'h20) $display("FAIL b2b_cmp1 got %h want 20", bus_a.rdata);
        else pass_n++;
        drv_a(1, 0, A_CMP0, 64'd0, 8'd0);
        @(negedge clk);
        chk_n++;
        if (bus_a.rdata !== 64'h0123456755667788)
            $display("FAIL b2b_cmp0 got %h want 0123456755667788", bus_a.rdata);
        else pass_n++;
        drv_a(0, 0, 64'd0, 64'd0, 8'd0);
        @(negedge clk);
        chk_n++;
        if (mtip_a !== 2'b10) $display("FAIL b2b_mtip got %b want 10", mtip_a);
        else pass_n++;
    endtask

    initial begin
        test_reset();
        test_idle_mtime();
        test_mtimecmp_tip();
        test_byte_mask();
        test_msip();
        test_unmapped();
        test_prescale();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_n, chk_n);
        $finish;
    end
endmodule
